mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind the ALU. Accepts one instruction at a
// time, issues at most one aligned 64-bit read or write on the data-memory
// port, and produces a single-cycle writeback pulse. Non-memory instructions
// complete with one cycle of latency.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exe_mem,
  input  logic [9:0]  opcode,
  input  logic [63:0] result,
  input  logic [63:0] mem_addr,
  input  logic [63:0] rflags_in,
  input  logic [3:0]  dest_reg,
  output logic        mem_blocked,
  output logic        dmem_req,
  output logic [63:0] dmem_addr,
  output logic        dmem_we,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic [3:0]  wb_reg,
  output logic [63:0] wb_data,
  output logic [63:0] wb_rflags,
  output logic        mem_err
);

  // One extra count of headroom: a grant on the final allowed MREQ cycle
  // leaves the counter at TIMEOUT, and the next increment must still compare.
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, DONE} state_e;

  state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic         dmem_req_q;
  logic         dmem_we_q;
  logic [63:0]  dmem_addr_q;
  logic [63:0]  dmem_wdata_q;
  logic         wb_valid_q;
  logic [3:0]   wb_reg_q;
  logic [63:0]  wb_data_q;
  logic [63:0]  wb_rflags_q;
  logic         mem_err_q;

  // Latched instruction fields, needed only once the transaction finishes.
  logic [63:0]  result_q;
  logic [63:0]  rflags_q;
  logic [3:0]   dest_q;
  logic         is_read_q;

  logic         rd_d;
  logic         wr_d;
  logic         mem_d;
  logic         misal_d;
  logic         acc_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic         timeout_d;

  function automatic logic is_read_op(input logic [9:0] op);
    return (op == 10'h040) || ((op >= 10'h058) && (op <= 10'h05F));
  endfunction

  function automatic logic is_write_op(input logic [9:0] op);
    return (op == 10'h048) || ((op >= 10'h050) && (op <= 10'h057)) ||
           (op == 10'h0E8) || (op == 10'h310);
  endfunction

  assign rd_d      = is_read_op(opcode);
  assign wr_d      = is_write_op(opcode);
  assign mem_d     = rd_d || wr_d;
  assign misal_d   = (mem_addr[2:0] != 3'b000);
  // DONE accepts a new instruction exactly like IDLE for back-to-back flow.
  assign acc_d     = exe_mem && ((state_q == IDLE) || (state_q == DONE));
  assign cnt_inc_d = cnt_q + CNT_W'(1);
  // Fires on the cycle whose increment would bring the wait count to TIMEOUT.
  assign timeout_d = (cnt_inc_d >= TO_VAL);

  // Busy indication back to the ALU; deliberately low in DONE.
  assign mem_blocked = (state_q == MREQ) || (state_q == MWAIT) ||
                       ((state_q == IDLE) && exe_mem && mem_d);

  assign dmem_req   = dmem_req_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
  assign wb_rflags  = wb_rflags_q;
  assign mem_err    = mem_err_q;

  // Capture the instruction fields whenever a new instruction is accepted.
  always_ff @(posedge clk) begin
    if (acc_d) begin
      result_q  <= result;
      rflags_q  <= rflags_in;
      dest_q    <= dest_reg;
      is_read_q <= rd_d;
    end
  end

  // Control FSM with registered memory-port and writeback outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      wb_rflags_q  <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (exe_mem) begin
            if (!mem_d || misal_d) begin
              // Pass-through, or a misaligned access that never reaches memory.
              wb_valid_q  <= 1'b1;
              wb_data_q   <= result;
              wb_reg_q    <= dest_reg;
              wb_rflags_q <= rflags_in;
              if (mem_d) begin
                mem_err_q <= 1'b1;
                state_q   <= DONE;
              end
            end else begin
              state_q      <= MREQ;
              cnt_q        <= '0;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= wr_d;
              dmem_addr_q  <= {mem_addr[63:3], 3'b000};
              dmem_wdata_q <= result;
            end
          end
        end
        MREQ: begin
          // A grant takes priority; any response in this cycle is ignored.
          if (dmem_gnt) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            cnt_q      <= cnt_inc_d;
            state_q    <= MWAIT;
          end else if (timeout_d) begin
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_err_q   <= 1'b1;
            wb_valid_q  <= 1'b1;
            wb_data_q   <= '0;
            wb_reg_q    <= dest_q;
            wb_rflags_q <= rflags_q;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        MWAIT: begin
          // A response in the timeout cycle still completes normally.
          if (dmem_rvalid) begin
            wb_valid_q  <= 1'b1;
            wb_data_q   <= is_read_q ? dmem_rdata : result_q;
            wb_reg_q    <= dest_q;
            wb_rflags_q <= rflags_q;
            state_q     <= DONE;
          end else if (timeout_d) begin
            mem_err_q   <= 1'b1;
            wb_valid_q  <= 1'b1;
            wb_data_q   <= '0;
            wb_reg_q    <= dest_q;
            wb_rflags_q <= rflags_q;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of single-cycle instruction
// vectors followed by hand-written multi-cycle memory sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exe_mem;
  logic [9:0]  opcode;
  logic [63:0] result;
  logic [63:0] mem_addr;
  logic [63:0] rflags_in;
  logic [3:0]  dest_reg;
  logic        mem_blocked;
  logic        dmem_req;
  logic [63:0] dmem_addr;
  logic        dmem_we;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [63:0] wb_data;
  logic [63:0] wb_rflags;
  logic        mem_err;

  int n_chk = 0;
  int n_bad = 0;
  int cyc;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .exe_mem(exe_mem), .opcode(opcode),
    .result(result), .mem_addr(mem_addr), .rflags_in(rflags_in),
    .dest_reg(dest_reg), .mem_blocked(mem_blocked), .dmem_req(dmem_req),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_rflags(wb_rflags), .mem_err(mem_err)
  );

  typedef struct {
    logic        exe;
    logic [9:0]  op;
    logic [63:0] res;
    logic [63:0] addr;
    logic [63:0] flags;
    logic [3:0]  dst;
    logic        blk;
    logic        wbv;
    logic [63:0] wbd;
    logic        err;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [9:0] op, input logic [63:0] res,
                       input logic [63:0] ad, input logic [63:0] fl, input logic [3:0] d);
    exe_mem   = e;
    opcode    = op;
    result    = res;
    mem_addr  = ad;
    rflags_in = fl;
    dest_reg  = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dmem_req"},    64'(dmem_req),    64'd0);
    chk({tag, "_dmem_we"},     64'(dmem_we),     64'd0);
    chk({tag, "_dmem_addr"},   dmem_addr,        64'd0);
    chk({tag, "_dmem_wdata"},  dmem_wdata,       64'd0);
    chk({tag, "_wb_valid"},    64'(wb_valid),    64'd0);
    chk({tag, "_wb_reg"},      64'(wb_reg),      64'd0);
    chk({tag, "_wb_data"},     wb_data,          64'd0);
    chk({tag, "_wb_rflags"},   wb_rflags,        64'd0);
    chk({tag, "_mem_err"},     64'(mem_err),     64'd0);
    chk({tag, "_mem_blocked"}, 64'(mem_blocked), 64'd0);
  endtask

  task automatic apply_reset();
    drive(1'b0, 10'h000, 64'd0, 64'd0, 64'd0, 4'd0);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    reset_n     = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    //          exe   op       res         addr         flags      dst  blk   wbv   wbd         err
    tbl[0]  = '{1'b1, 10'h001, 64'h5,      64'h0,       64'h11,    4'd3,  1'b0, 1'b1, 64'h5,      1'b0};
    tbl[1]  = '{1'b0, 10'h000, 64'h0,      64'h0,       64'h0,     4'd0,  1'b0, 1'b0, 64'h0,      1'b0};
    tbl[2]  = '{1'b1, 10'h0FF, 64'hA5A5,   64'h0,       64'h12,    4'd15, 1'b0, 1'b1, 64'hA5A5,   1'b0};
    tbl[3]  = '{1'b1, 10'h047, 64'h1234,   64'h8,       64'h13,    4'd7,  1'b0, 1'b1, 64'h1234,   1'b0};
    tbl[4]  = '{1'b1, 10'h060, 64'h5678,   64'h10,      64'h14,    4'd8,  1'b0, 1'b1, 64'h5678,   1'b0};
    tbl[5]  = '{1'b1, 10'h311, 64'h9ABC,   64'h1003,    64'h15,    4'd9,  1'b0, 1'b1, 64'h9ABC,   1'b0};
    tbl[6]  = '{1'b0, 10'h040, 64'h0,      64'h0,       64'h0,     4'd0,  1'b0, 1'b0, 64'h0,      1'b0};
    tbl[7]  = '{1'b1, 10'h048, 64'h99,     64'h1003,    64'h22,    4'd2,  1'b1, 1'b1, 64'h99,     1'b1};
    tbl[8]  = '{1'b1, 10'h05F, 64'h42,     64'h2001,    64'h23,    4'd4,  1'b0, 1'b1, 64'h42,     1'b1};
    tbl[9]  = '{1'b0, 10'h000, 64'h0,      64'h0,       64'h0,     4'd0,  1'b0, 1'b0, 64'h0,      1'b1};
    tbl[10] = '{1'b1, 10'h0E8, 64'h5,      64'h7,       64'h24,    4'd11, 1'b1, 1'b1, 64'h5,      1'b1};
    tbl[11] = '{1'b0, 10'h000, 64'h0,      64'h0,       64'h0,     4'd0,  1'b0, 1'b0, 64'h0,      1'b1};
    tbl[12] = '{1'b1, 10'h310, 64'h6,      64'h4,       64'h25,    4'd1,  1'b1, 1'b1, 64'h6,      1'b1};
    tbl[13] = '{1'b0, 10'h000, 64'h0,      64'h0,       64'h0,     4'd0,  1'b0, 1'b0, 64'h0,      1'b1};
    tbl[14] = '{1'b1, 10'h058, 64'h7,      64'hF,       64'h26,    4'd12, 1'b1, 1'b1, 64'h7,      1'b1};
    tbl[15] = '{1'b0, 10'h000, 64'h0,      64'h0,       64'h0,     4'd0,  1'b0, 1'b0, 64'h0,      1'b1};

    // Reset state
    reset_n     = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'd0;
    drive(1'b0, 10'h000, 64'd0, 64'd0, 64'd0, 4'd0);
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Table: pass-through, opcode-class boundaries and misaligned accesses
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].exe, tbl[i].op, tbl[i].res, tbl[i].addr, tbl[i].flags, tbl[i].dst);
      #1;
      chk($sformatf("v%0d_mem_blocked", i), 64'(mem_blocked), 64'(tbl[i].blk));
      tick();
      chk($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'(tbl[i].wbv));
      chk($sformatf("v%0d_dmem_req", i), 64'(dmem_req), 64'd0);
      chk($sformatf("v%0d_mem_err", i),  64'(mem_err),  64'(tbl[i].err));
      if (tbl[i].wbv) begin
        chk($sformatf("v%0d_wb_data", i),   wb_data,       tbl[i].wbd);
        chk($sformatf("v%0d_wb_reg", i),    64'(wb_reg),   64'(tbl[i].dst));
        chk($sformatf("v%0d_wb_rflags", i), wb_rflags,     tbl[i].flags);
      end
    end

    // LOAD: grant in first MREQ cycle, response after two MWAIT cycles
    apply_reset();
    drive(1'b1, 10'h040, 64'h0, 64'h1000, 64'hF0, 4'd5);
    #1;
    chk("load_c0_blocked", 64'(mem_blocked), 64'd1);
    tick();
    drive(1'b0, 10'h000, 64'h0, 64'h0, 64'h0, 4'd0);
    dmem_gnt = 1'b1;
    #1;
    chk("load_mreq_req", 64'(dmem_req), 64'd1);
    chk("load_mreq_addr", dmem_addr, 64'h1000);
    chk("load_mreq_we", 64'(dmem_we), 64'd0);
    chk("load_mreq_blocked", 64'(mem_blocked), 64'd1);
    tick();
    dmem_gnt = 1'b0;
    chk("load_mwait1_req", 64'(dmem_req), 64'd0);
    chk("load_mwait1_blocked", 64'(mem_blocked), 64'd1);
    chk("load_mwait1_wb_valid", 64'(wb_valid), 64'd0);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hDEADBEEF;
    chk("load_mwait2_blocked", 64'(mem_blocked), 64'd1);
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'h0;
    chk("load_done_wb_valid", 64'(wb_valid), 64'd1);
    chk("load_done_wb_data", wb_data, 64'hDEADBEEF);
    chk("load_done_wb_reg", 64'(wb_reg), 64'd5);
    chk("load_done_wb_rflags", wb_rflags, 64'hF0);
    chk("load_done_blocked", 64'(mem_blocked), 64'd0);
    chk("load_done_mem_err", 64'(mem_err), 64'd0);
    tick();
    chk("load_after_wb_valid", 64'(wb_valid), 64'd0);

    // PUSH: grant withheld 3 cycles; response arriving with the grant is ignored
    drive(1'b1, 10'h050, 64'h77, 64'h2008, 64'h3C, 4'd6);
    tick();
    drive(1'b0, 10'h000, 64'h0, 64'h0, 64'h0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      dmem_gnt    = (i == 3);
      dmem_rvalid = (i == 3);
      dmem_rdata  = 64'hBAD;
      #1;
      chk($sformatf("push_mreq%0d_req", i),   64'(dmem_req), 64'd1);
      chk($sformatf("push_mreq%0d_addr", i),  dmem_addr,     64'h2008);
      chk($sformatf("push_mreq%0d_wdata", i), dmem_wdata,    64'h77);
      chk($sformatf("push_mreq%0d_we", i),    64'(dmem_we),  64'd1);
      tick();
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    chk("push_mwait_req", 64'(dmem_req), 64'd0);
    chk("push_mwait_wb_valid", 64'(wb_valid), 64'd0);
    chk("push_mwait_blocked", 64'(mem_blocked), 64'd1);
    tick();
    dmem_rvalid = 1'b0;
    chk("push_done_wb_valid", 64'(wb_valid), 64'd1);
    chk("push_done_wb_data", wb_data, 64'h77);
    chk("push_done_wb_reg", 64'(wb_reg), 64'd6);
    chk("push_done_mem_err", 64'(mem_err), 64'd0);
    tick();
    chk("push_after_wb_valid", 64'(wb_valid), 64'd0);

    // Timeout: READ never granted
    apply_reset();
    chk("timeout_pre_mem_err", 64'(mem_err), 64'd0);
    drive(1'b1, 10'h05A, 64'h1111, 64'h3000, 64'h55, 4'd9);
    tick();
    drive(1'b0, 10'h000, 64'h0, 64'h0, 64'h0, 4'd0);
    chk("timeout_mreq_req", 64'(dmem_req), 64'd1);
    cyc = 1;
    while (wb_valid !== 1'b1 && cyc < 12) begin
      tick();
      cyc++;
    end
    chk("timeout_wb_valid_seen", 64'(wb_valid), 64'd1);
    chk("timeout_latency_window", 64'((cyc >= 5) && (cyc <= 6)), 64'd1);
    chk("timeout_mem_err", 64'(mem_err), 64'd1);
    chk("timeout_wb_data", wb_data, 64'd0);
    chk("timeout_wb_reg", 64'(wb_reg), 64'd9);
    chk("timeout_wb_rflags", wb_rflags, 64'h55);
    chk("timeout_req_dropped", 64'(dmem_req), 64'd0);
    tick();
    chk("timeout_after_wb_valid", 64'(wb_valid), 64'd0);
    drive(1'b1, 10'h002, 64'hCAFE, 64'h0, 64'h1, 4'd10);
    #1;
    chk("post_timeout_pass_blocked", 64'(mem_blocked), 64'd0);
    tick();
    drive(1'b0, 10'h000, 64'h0, 64'h0, 64'h0, 4'd0);
    chk("post_timeout_pass_wb_valid", 64'(wb_valid), 64'd1);
    chk("post_timeout_pass_wb_data", wb_data, 64'hCAFE);
    chk("post_timeout_pass_wb_reg", 64'(wb_reg), 64'd10);
    tick();

    // Reset while in MWAIT, then a late response
    drive(1'b1, 10'h040, 64'h0, 64'h4000, 64'h7, 4'd13);
    tick();
    drive(1'b0, 10'h000, 64'h0, 64'h0, 64'h0, 4'd0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rst_mwait_blocked", 64'(mem_blocked), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n     = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h1234;
    chk_all_zero("rst_mwait");
    tick();
    dmem_rvalid = 1'b0;
    chk("rst_late_rvalid_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_late_rvalid_wb_data", wb_data, 64'd0);
    chk("rst_late_rvalid_blocked", 64'(mem_blocked), 64'd0);
    drive(1'b1, 10'h003, 64'h9, 64'h0, 64'h2, 4'd14);
    tick();
    drive(1'b0, 10'h000, 64'h0, 64'h0, 64'h0, 4'd0);
    chk("rst_then_pass_wb_valid", 64'(wb_valid), 64'd1);
    chk("rst_then_pass_wb_data", wb_data, 64'h9);
    tick();
    chk("rst_then_pass_single_pulse", 64'(wb_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
